uart_rx_stream: RTL and testbench

- Receives 8N1 (optionally parity) asynchronous serial data from the UART Lite TX pin (uart_rtl_txd) and delivers each byte on an AXI4-Stream master interface.
- Sits between the UART pins and the PITCH message parser.
- Provides the host-to-FPGA direction that the UART loopback path exercises.
- Flags framing, parity and overrun errors.

---
 rtl/uart_rx_stream.sv | 175 +++++++++++++++++
 tb/tb_uart_rx_stream.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_stream.sv
// uart_rx_stream
// Receives asynchronous serial frames (start, 8 data bits LSB first, optional
// parity, one stop bit) from the UART TX pin and presents each received byte
// on an AXI4-Stream master interface with a single holding register.
//
// Ports:
//   aclk           clock; every flop updates on its rising edge
//   aresetn        synchronous active-low reset
//   uart_rtl_rxd   asynchronous serial input, idle high
//   m_axis_tdata   received byte (bit 0 = first data bit on the wire)
//   m_axis_tvalid  byte available in the holding register
//   m_axis_tready  downstream accepts the byte
//   m_axis_tuser   parity error flag for the byte in tdata
//   frame_err      one-cycle pulse when the stop bit is sampled low
//   overrun_err    one-cycle pulse when a byte is dropped (holding register full)
//   busy           receiver is inside a frame (FSM not idle)
module uart_rx_stream #(
   parameter int CLKS_PER_BIT = 868,
   parameter int PARITY       = 0,
   parameter int SYNC_STAGES  = 2
) (
   input  logic       aclk,
   input  logic       aresetn,
   input  logic       uart_rtl_rxd,
   output logic [7:0] m_axis_tdata,
   output logic       m_axis_tvalid,
   input  logic       m_axis_tready,
   output logic       m_axis_tuser,
   output logic       frame_err,
   output logic       overrun_err,
   output logic       busy
);

   localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);
   localparam logic [15:0] HALF     = 16'(CLKS_PER_BIT / 2);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t                 state;
   logic [SYNC_STAGES-1:0] sync_p;
   logic                   rxd_s;
   logic [15:0]            baud_cnt;
   logic [2:0]             bit_idx;
   logic [7:0]             shift;
   logic                   perr;
   logic                   brk;

   // Parity error for the received byte: even parity expects XOR of data and
   // parity bit to be 0; odd parity expects it to be 1.
   function automatic logic parity_err(input logic [7:0] d, input logic s);
      logic e;
      e = (^d) ^ s;
      return (PARITY == 2) ? ~e : e;
   endfunction

   // ---- synchroniser stage: rxd_s is the only view of the line the FSM uses
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         sync_p <= '1;
      end else begin
         sync_p <= {sync_p[SYNC_STAGES-2:0], uart_rtl_rxd};
      end
   end

   assign rxd_s = sync_p[SYNC_STAGES-1];
   assign busy  = (state != S_IDLE);

   // ---- receive FSM and holding register
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state         <= S_IDLE;
         baud_cnt      <= '0;
         bit_idx       <= '0;
         shift         <= '0;
         perr          <= 1'b0;
         brk           <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tvalid <= 1'b0;
         m_axis_tuser  <= 1'b0;
         frame_err     <= 1'b0;
         overrun_err   <= 1'b0;
      end else begin
         frame_err   <= 1'b0;
         overrun_err <= 1'b0;

         // Handshake empties the holding register; a delivery below in the
         // same cycle overrides this and keeps tvalid high.
         if (m_axis_tvalid && m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
         end

         case (state)
            S_IDLE: begin
               baud_cnt <= '0;
               if (!rxd_s) begin
                  state <= S_START;
               end
            end

            S_START: begin
               if (baud_cnt == HALF) begin
                  baud_cnt <= '0;
                  bit_idx  <= '0;
                  // Line back high at mid start bit: a glitch, not a frame.
                  state    <= rxd_s ? S_IDLE : S_DATA;
               end else begin
                  baud_cnt <= baud_cnt + 16'd1;
               end
            end

            S_DATA: begin
               if (baud_cnt == BIT_LAST) begin
                  baud_cnt       <= '0;
                  shift[bit_idx] <= rxd_s;
                  bit_idx        <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) begin
                     state <= (PARITY != 0) ? S_PARITY : S_STOP;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 16'd1;
               end
            end

            S_PARITY: begin
               if (baud_cnt == BIT_LAST) begin
                  baud_cnt <= '0;
                  perr     <= parity_err(shift, rxd_s);
                  state    <= S_STOP;
               end else begin
                  baud_cnt <= baud_cnt + 16'd1;
               end
            end

            S_STOP: begin
               if (brk) begin
                  // Framing error seen: hold here until the line is released
                  // so a break condition cannot look like a new start bit.
                  if (rxd_s) begin
                     brk   <= 1'b0;
                     state <= S_IDLE;
                  end
               end else if (baud_cnt == BIT_LAST) begin
                  baud_cnt <= '0;
                  if (rxd_s) begin
                     if (!m_axis_tvalid || m_axis_tready) begin
                        m_axis_tdata  <= shift;
                        m_axis_tuser  <= perr;
                        m_axis_tvalid <= 1'b1;
                     end else begin
                        overrun_err <= 1'b1;
                     end
                     state <= S_IDLE;
                  end else begin
                     frame_err <= 1'b1;
                     brk       <= 1'b1;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 16'd1;
               end
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_stream.sv
// tb_uart_rx_stream
// Directed bench for uart_rx_stream. Instance u0 runs without parity, u1 with
// even parity; both use 16 clocks per bit and a 2-flop synchroniser.
module tb_uart_rx_stream;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       aresetn;
  logic [1:0] rxd;
  logic [1:0] tready;
  logic [1:0] tvalid;
  logic [1:0] tuser;
  logic [1:0] ferr;
  logic [1:0] ovr;
  logic [1:0] busy;
  logic [7:0] tdata [2];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  int         beats    [2] = '{0, 0};
  int         ferr_cnt [2] = '{0, 0};
  int         ovr_cnt  [2] = '{0, 0};
  int         busy_cyc [2] = '{0, 0};
  int         rise_cyc [2] = '{0, 0};
  logic       prev_vld [2] = '{1'b0, 1'b0};
  logic [7:0] last_data[2] = '{8'h00, 8'h00};
  logic       last_user[2] = '{1'b0, 1'b0};

  int s_beats, s_ferr, s_ovr, s_busy, t0, lat;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_stream #(.CLKS_PER_BIT(CPB), .PARITY(0), .SYNC_STAGES(2)) u0 (
    .aclk(clk), .aresetn(aresetn), .uart_rtl_rxd(rxd[0]),
    .m_axis_tdata(tdata[0]), .m_axis_tvalid(tvalid[0]), .m_axis_tready(tready[0]),
    .m_axis_tuser(tuser[0]), .frame_err(ferr[0]), .overrun_err(ovr[0]), .busy(busy[0])
  );

  uart_rx_stream #(.CLKS_PER_BIT(CPB), .PARITY(1), .SYNC_STAGES(2)) u1 (
    .aclk(clk), .aresetn(aresetn), .uart_rtl_rxd(rxd[1]),
    .m_axis_tdata(tdata[1]), .m_axis_tvalid(tvalid[1]), .m_axis_tready(tready[1]),
    .m_axis_tuser(tuser[1]), .frame_err(ferr[1]), .overrun_err(ovr[1]), .busy(busy[1])
  );

  // Event monitor, sampled away from the active edge.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (tvalid[i] && tready[i]) begin
        beats[i]++;
        last_data[i] = tdata[i];
        last_user[i] = tuser[i];
      end
      if (tvalid[i] && !prev_vld[i]) rise_cyc[i] = cyc;
      prev_vld[i] = tvalid[i];
      if (ferr[i]) ferr_cnt[i]++;
      if (ovr[i])  ovr_cnt[i]++;
      if (busy[i]) busy_cyc[i]++;
    end
  end

  task automatic fail(input string tag, input int obs, input int exp);
    failures++;
    $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic drive_bit(input int sel, input logic v);
    rxd[sel] = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send(input int sel, input logic [7:0] d, input bit par_en,
                      input logic pbit, input logic stopb);
    drive_bit(sel, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(sel, d[i]);
    if (par_en) drive_bit(sel, pbit);
    drive_bit(sel, stopb);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rxd     = 2'b11;
    tready  = 2'b11;
    aresetn = 1'b0;
    wait_cycles(3);

    // Reset state
    checks++; if (tvalid[0] !== 1'b0) fail("rst_tvalid", tvalid[0], 0);
    checks++; if (tdata[0] !== 8'h00) fail("rst_tdata", tdata[0], 0);
    checks++; if (busy !== 2'b00) fail("rst_busy", busy, 0);
    checks++; if (ferr[0] !== 1'b0) fail("rst_ferr", ferr[0], 0);
    checks++; if (ovr[0] !== 1'b0) fail("rst_ovr", ovr[0], 0);
    aresetn = 1'b1;

    // Idle line for 2000 cycles
    s_beats = beats[0]; s_ferr = ferr_cnt[0]; s_ovr = ovr_cnt[0]; s_busy = busy_cyc[0];
    wait_cycles(2000);
    checks++; if (beats[0] - s_beats != 0) fail("idle_beats", beats[0] - s_beats, 0);
    checks++; if (ferr_cnt[0] - s_ferr != 0) fail("idle_ferr", ferr_cnt[0] - s_ferr, 0);
    checks++; if (ovr_cnt[0] - s_ovr != 0) fail("idle_ovr", ovr_cnt[0] - s_ovr, 0);
    checks++; if (busy_cyc[0] - s_busy != 0) fail("idle_busy", busy_cyc[0] - s_busy, 0);
    checks++; if (tdata[0] !== 8'h00) fail("idle_tdata", tdata[0], 0);

    // 0xA5, 8N1, tready high
    s_beats = beats[0]; s_ferr = ferr_cnt[0];
    t0 = cyc;
    send(0, 8'hA5, 1'b0, 1'b0, 1'b1);
    wait_cycles(20);
    checks++; if (beats[0] - s_beats != 1) fail("a5_beats", beats[0] - s_beats, 1);
    checks++; if (last_data[0] !== 8'hA5) fail("a5_data", last_data[0], 8'hA5);
    checks++; if (last_user[0] !== 1'b0) fail("a5_user", last_user[0], 0);
    checks++; if (ferr_cnt[0] - s_ferr != 0) fail("a5_ferr", ferr_cnt[0] - s_ferr, 0);
    checks++; if (tvalid[0] !== 1'b0) fail("a5_tvalid_low", tvalid[0], 0);
    lat = rise_cyc[0] - t0;
    checks++;
    if (lat < 150 || lat > 160) begin
      failures++;
      $error("FAIL a5_latency observed=%0d expected=150..160", lat);
    end

    // Overrun: tready low, 0x3C then 0xC3
    tready[0] = 1'b0;
    s_beats = beats[0]; s_ovr = ovr_cnt[0];
    send(0, 8'h3C, 1'b0, 1'b0, 1'b1);
    send(0, 8'hC3, 1'b0, 1'b0, 1'b1);
    wait_cycles(20);
    checks++; if (tvalid[0] !== 1'b1) fail("ovr_tvalid", tvalid[0], 1);
    checks++; if (tdata[0] !== 8'h3C) fail("ovr_tdata", tdata[0], 8'h3C);
    checks++; if (ovr_cnt[0] - s_ovr != 1) fail("ovr_pulses", ovr_cnt[0] - s_ovr, 1);
    checks++; if (beats[0] - s_beats != 0) fail("ovr_beats_held", beats[0] - s_beats, 0);
    tready[0] = 1'b1;
    wait_cycles(50);
    checks++; if (beats[0] - s_beats != 1) fail("ovr_beats_release", beats[0] - s_beats, 1);
    checks++; if (last_data[0] !== 8'h3C) fail("ovr_data_release", last_data[0], 8'h3C);
    checks++; if (tvalid[0] !== 1'b0) fail("ovr_tvalid_low", tvalid[0], 0);

    // Framing error with a held-low line
    s_beats = beats[0]; s_ferr = ferr_cnt[0];
    send(0, 8'h55, 1'b0, 1'b0, 1'b0);
    rxd[0] = 1'b0;
    wait_cycles(40);
    checks++; if (busy[0] !== 1'b1) fail("ferr_busy_in_break", busy[0], 1);
    rxd[0] = 1'b1;
    wait_cycles(10);
    checks++; if (busy[0] !== 1'b0) fail("ferr_busy_released", busy[0], 0);
    checks++; if (ferr_cnt[0] - s_ferr != 1) fail("ferr_pulses", ferr_cnt[0] - s_ferr, 1);
    wait_cycles(200);
    checks++; if (beats[0] - s_beats != 0) fail("ferr_no_beats", beats[0] - s_beats, 0);
    checks++; if (ferr_cnt[0] - s_ferr != 1) fail("ferr_pulses_after", ferr_cnt[0] - s_ferr, 1);
    checks++; if (busy[0] !== 1'b0) fail("ferr_busy_after", busy[0], 0);

    // 4-cycle glitch on an idle line
    s_beats = beats[0]; s_busy = busy_cyc[0];
    rxd[0] = 1'b0;
    wait_cycles(4);
    rxd[0] = 1'b1;
    wait_cycles(16);
    checks++; if (busy[0] !== 1'b0) fail("glitch_busy_low", busy[0], 0);
    checks++;
    if ((busy_cyc[0] - s_busy) < 1 || (busy_cyc[0] - s_busy) > 9) begin
      failures++;
      $error("FAIL glitch_busy_cycles observed=%0d expected=1..9", busy_cyc[0] - s_busy);
    end
    wait_cycles(200);
    checks++; if (beats[0] - s_beats != 0) fail("glitch_no_beats", beats[0] - s_beats, 0);

    // Even parity, 0x07 (three ones): parity bit 0 is wrong, 1 is right
    s_beats = beats[1];
    send(1, 8'h07, 1'b1, 1'b0, 1'b1);
    wait_cycles(20);
    checks++; if (beats[1] - s_beats != 1) fail("par_bad_beats", beats[1] - s_beats, 1);
    checks++; if (last_data[1] !== 8'h07) fail("par_bad_data", last_data[1], 8'h07);
    checks++; if (last_user[1] !== 1'b1) fail("par_bad_user", last_user[1], 1);
    send(1, 8'h07, 1'b1, 1'b1, 1'b1);
    wait_cycles(20);
    checks++; if (beats[1] - s_beats != 2) fail("par_ok_beats", beats[1] - s_beats, 2);
    checks++; if (last_data[1] !== 8'h07) fail("par_ok_data", last_data[1], 8'h07);
    checks++; if (last_user[1] !== 1'b0) fail("par_ok_user", last_user[1], 0);

    // Reset in the middle of the data bits
    s_beats = beats[1];
    drive_bit(1, 1'b0);
    drive_bit(1, 1'b1);
    drive_bit(1, 1'b0);
    checks++; if (busy[1] !== 1'b1) fail("midrst_busy_before", busy[1], 1);
    aresetn = 1'b0;
    wait_cycles(1);
    checks++; if (busy[1] !== 1'b0) fail("midrst_busy", busy[1], 0);
    checks++; if (tvalid[1] !== 1'b0) fail("midrst_tvalid", tvalid[1], 0);
    aresetn = 1'b1;
    rxd[1]  = 1'b1;
    wait_cycles(300);
    checks++; if (beats[1] - s_beats != 0) fail("midrst_no_beats", beats[1] - s_beats, 0);
    checks++; if (ferr[1] !== 1'b0) fail("midrst_ferr", ferr[1], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
